mouse_analog_emu: RTL

Parametrised PS/2-mouse-to-analog-stick emulator for the console cores; successor to the fixed 8-bit, two-axis, hold-position mouse path in the emu top level. It accumulates relative mouse packets into saturating signed axis positions. It supports per-axis inversion, optional self-centering and an inactivity timeout, and hands ownership back to the physical analog stick. It sits in the emu wrapper between hps_io (PS2_MOUSE, joystick analog) and the core's JOY1X/JOY1Y/fire inputs.

---
 rtl/mouse_analog_emu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mouse_analog_emu.sv
// PS/2 mouse packets accumulated into saturating signed analog-stick positions,
// with optional self-centering, inactivity release and hand-back to the real stick.
module mouse_analog_emu #(
  parameter int AXIS_W    = 8,
  parameter int SHIFT     = 1,
  parameter int MAX_STEP  = 10,
  parameter int DECAY_DIV = 4,
  parameter int TIMEOUT   = 0
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [24:0]         PS2_MOUSE,
  input  logic [2*AXIS_W-1:0] JOY_ANALOG,
  input  logic                HALT,
  input  logic                INVERT_X,
  input  logic                INVERT_Y,
  input  logic                CENTER_EN,
  input  logic                CENTER_TICK,
  output logic [AXIS_W-1:0]   AX,
  output logic [AXIS_W-1:0]   AY,
  output logic [1:0]          BTN,
  output logic                EMU_ACTIVE
);

  localparam int SUM_W = AXIS_W + 2;
  localparam logic signed [9:0]       STEP_HI  = 10'(MAX_STEP);
  localparam logic signed [9:0]       STEP_LO  = -STEP_HI;
  localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((1 << (AXIS_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO   = ~SAT_HI;
  localparam logic [7:0]              DEC_LAST = 8'(DECAY_DIV - 1);
  localparam logic [15:0]             TO_LIMIT = 16'(TIMEOUT);
  localparam logic                    TO_EN    = (TIMEOUT != 32'sd0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MOUSE = 1'b1} state_t;

  state_t                    state_r, state_s;
  logic                      prev_strobe_r;
  logic signed [AXIS_W-1:0]  acc_x_r, acc_x_s, acc_y_r, acc_y_s;
  logic [7:0]                dec_cnt_r, dec_cnt_s;
  logic [15:0]               to_cnt_r, to_cnt_s;
  logic [AXIS_W-1:0]         ax_r, ay_r;
  logic [1:0]                btn_r;
  logic                      active_r;
  logic                      pkt_s, joy_busy_s, timeout_s, decay_step_s, unused_s;

  // Shift, clamp, optionally negate a 9-bit packet delta and add it with saturation.
  function automatic logic signed [AXIS_W-1:0] axis_step(
    input logic signed [AXIS_W-1:0] acc,
    input logic                     sgn,
    input logic [7:0]               mag,
    input logic                     inv
  );
    logic signed [9:0]       d;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] res;
    d = $signed({sgn, sgn, mag}) >>> SHIFT;
    if (d > STEP_HI) d = STEP_HI;
    else if (d < STEP_LO) d = STEP_LO;
    if (inv) d = -d;
    sum = SUM_W'(acc) + SUM_W'(d);
    if (sum > SAT_HI) res = SAT_HI;
    else if (sum < SAT_LO) res = SAT_LO;
    else res = sum;
    return res[AXIS_W-1:0];
  endfunction

  // One centering step: a nonzero accumulator moves by 1 toward 0.
  function automatic logic signed [AXIS_W-1:0] toward_zero(input logic signed [AXIS_W-1:0] acc);
    if (acc[AXIS_W-1]) return acc + AXIS_W'(1);
    else if (|acc) return acc - AXIS_W'(1);
    else return acc;
  endfunction

  assign pkt_s      = PS2_MOUSE[24] ^ prev_strobe_r;
  assign joy_busy_s = |JOY_ANALOG;
  assign timeout_s  = TO_EN && (to_cnt_r == TO_LIMIT);
  assign unused_s   = ^{PS2_MOUSE[7:6], PS2_MOUSE[3:2]};

  // Ownership, accumulation, centering and timeout next-state logic.
  always_comb begin
    state_s      = state_r;
    acc_x_s      = acc_x_r;
    acc_y_s      = acc_y_r;
    dec_cnt_s    = dec_cnt_r;
    to_cnt_s     = to_cnt_r;
    decay_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dec_cnt_s = 8'd0;
        to_cnt_s  = 16'd0;
        if (pkt_s && !joy_busy_s && !HALT) begin
          state_s = ST_MOUSE;
          acc_x_s = axis_step('0, PS2_MOUSE[4], PS2_MOUSE[15:8], INVERT_X);
          acc_y_s = axis_step('0, PS2_MOUSE[5], PS2_MOUSE[23:16], INVERT_Y);
        end else begin
          acc_x_s = '0;
          acc_y_s = '0;
        end
      end
      ST_MOUSE: begin
        if (joy_busy_s || HALT || timeout_s) begin
          state_s   = ST_IDLE;
          acc_x_s   = '0;
          acc_y_s   = '0;
          dec_cnt_s = 8'd0;
          to_cnt_s  = 16'd0;
        end else begin
          if (!CENTER_EN) begin
            dec_cnt_s = 8'd0;
          end else if (CENTER_TICK) begin
            if (dec_cnt_r == DEC_LAST) begin
              dec_cnt_s    = 8'd0;
              decay_step_s = 1'b1;
            end else begin
              dec_cnt_s = dec_cnt_r + 8'd1;
            end
          end else begin
            dec_cnt_s = dec_cnt_r;
          end
          // A packet wins over a coincident centering step.
          if (pkt_s) begin
            acc_x_s = axis_step(acc_x_r, PS2_MOUSE[4], PS2_MOUSE[15:8], INVERT_X);
            acc_y_s = axis_step(acc_y_r, PS2_MOUSE[5], PS2_MOUSE[23:16], INVERT_Y);
          end else if (decay_step_s) begin
            acc_x_s = toward_zero(acc_x_r);
            acc_y_s = toward_zero(acc_y_r);
          end else begin
            acc_x_s = acc_x_r;
            acc_y_s = acc_y_r;
          end
          if (pkt_s) to_cnt_s = 16'd0;
          else if (CENTER_TICK && (to_cnt_r != 16'hFFFF)) to_cnt_s = to_cnt_r + 16'd1;
          else to_cnt_s = to_cnt_r;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        acc_x_s   = '0;
        acc_y_s   = '0;
        dec_cnt_s = 8'd0;
        to_cnt_s  = 16'd0;
      end
    endcase
  end

  // State, accumulator and counter registers; strobe history reloads on reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r       <= ST_IDLE;
      prev_strobe_r <= PS2_MOUSE[24];
      acc_x_r       <= '0;
      acc_y_r       <= '0;
      dec_cnt_r     <= 8'd0;
      to_cnt_r      <= 16'd0;
    end else begin
      state_r       <= state_s;
      prev_strobe_r <= PS2_MOUSE[24];
      acc_x_r       <= acc_x_s;
      acc_y_r       <= acc_y_s;
      dec_cnt_r     <= dec_cnt_s;
      to_cnt_r      <= to_cnt_s;
    end
  end

  // Registered output mux between the mouse accumulators and the physical stick.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ax_r     <= '0;
      ay_r     <= '0;
      btn_r    <= 2'b00;
      active_r <= 1'b0;
    end else if (state_r == ST_MOUSE) begin
      ax_r     <= acc_x_r;
      ay_r     <= acc_y_r;
      btn_r    <= PS2_MOUSE[1:0];
      active_r <= 1'b1;
    end else begin
      ax_r     <= JOY_ANALOG[AXIS_W-1:0];
      ay_r     <= JOY_ANALOG[2*AXIS_W-1:AXIS_W];
      btn_r    <= 2'b00;
      active_r <= 1'b0;
    end
  end

  assign AX         = ax_r;
  assign AY         = ay_r;
  assign BTN        = btn_r;
  assign EMU_ACTIVE = active_r;

endmodule
